// File: rtl/aes_pkg.sv
// Shared AES constants and helpers used by the forward and inverse key schedules.
// Pure declarations; no logic, no latency.
package aes_pkg;

    localparam int NUM_ROUNDS_DEFAULT = 10;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Round constant sits in the most significant byte of the word.
    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] b;
        case (r)
            4'd1:    b = 8'h01;
            4'd2:    b = 8'h02;
            4'd3:    b = 8'h04;
            4'd4:    b = 8'h08;
            4'd5:    b = 8'h10;
            4'd6:    b = 8'h20;
            4'd7:    b = 8'h40;
            4'd8:    b = 8'h80;
            4'd9:    b = 8'h1b;
            4'd10:   b = 8'h36;
            default: b = 8'h00;
        endcase
        return {b, 24'h0};
    endfunction

endpackage

// File: rtl/SubBytes.sv
// Byte-wise AES S-box substitution over numbytes lanes.
// Purely combinational, no handshake.
module SubBytes #(
    parameter int numbytes = 16
) (
    input  logic [8*numbytes-1:0] data_i,
    output logic [8*numbytes-1:0] data_o
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    for (genvar i = 0; i < numbytes; i++) begin : g_lane
        assign data_o[8*i +: 8] = SBOX[data_i[8*i +: 8]];
    end

endmodule

// File: rtl/inv_key_step.sv
// One backwards step of the AES-128 key schedule: round-r key -> round-(r-1) key.
// Purely combinational; round_i selects the Rcon used to produce the round-r key.
module inv_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key_i,
    input  logic [3:0]   round_i,
    output logic [127:0] prev_key_o
);
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot_w, sub_w;

    assign {n3, n2, n1, n0} = key_i;

    // Upper three words unwind by neighbouring XOR; only w0 needs the S-box.
    assign p3    = n3 ^ n2;
    assign p2    = n2 ^ n1;
    assign p1    = n1 ^ n0;
    assign rot_w = {p3[23:0], p3[31:24]};

    SubBytes #(
        .numbytes(4)
    ) u_sub_word (
        .data_i(rot_w),
        .data_o(sub_w)
    );

    assign p0         = n0 ^ sub_w ^ rcon(round_i);
    assign prev_key_o = {p3, p2, p1, p0};

endmodule

// File: rtl/inv_key_schedule.sv
// Emits AES-128 round keys NumRounds..0 one per cycle from the loaded last key; first key 1 cycle after start.
// Holds key/round/valid stable while KeyReady is low; StartReady only in IDLE.
module inv_key_schedule
    import aes_pkg::*;
#(
    parameter int NumRounds = NUM_ROUNDS_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] LastKey,
    input  logic         StartValid,
    output logic         StartReady,
    output logic [127:0] RoundKey,
    output logic [3:0]   RoundNumber,
    output logic         KeyValid,
    input  logic         KeyReady,
    output logic         Busy
);
    localparam logic [3:0] LastRound = 4'(NumRounds);

    state_e       state_q;
    logic [127:0] key_q;
    logic [3:0]   round_q;
    logic         valid_q;
    logic         start_rdy_q;
    logic [127:0] prev_key_d;

    inv_key_step u_step (
        .key_i     (key_q),
        .round_i   (round_q),
        .prev_key_o(prev_key_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_q       <= '0;
            round_q     <= '0;
            valid_q     <= 1'b0;
            start_rdy_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (StartValid) begin
                        key_q       <= LastKey;
                        round_q     <= LastRound;
                        valid_q     <= 1'b1;
                        start_rdy_q <= 1'b0;
                        state_q     <= EMIT;
                    end
                end
                EMIT: begin
                    if (KeyReady) begin
                        if (round_q != 4'd0) begin
                            key_q   <= prev_key_d;
                            round_q <= round_q - 4'd1;
                        end else begin
                            // Round-0 key stays on the bus for inspection; only valid drops.
                            valid_q     <= 1'b0;
                            start_rdy_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_q     <= 1'b0;
                    start_rdy_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign StartReady  = start_rdy_q;
    assign KeyValid    = valid_q;
    assign Busy        = valid_q;
    assign RoundKey    = key_q;
    assign RoundNumber = round_q;

endmodule
